// File: rtl/dft_axil_master_if.sv
// Command/response port plus AXI4-Lite master channels for dft_axil_master.
// The master modport is the initiator; the slave modport is the command source and bus target.
interface dft_axil_master_if #(
    parameter int unsigned ADDR_WIDTH = 24
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;
    logic [3:0]            cmd_wstrb;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  axi_m_awvalid;
    logic                  axi_m_awready;
    logic [ADDR_WIDTH-1:0] axi_m_awaddr;
    logic [2:0]            axi_m_awprot;
    logic                  axi_m_wvalid;
    logic                  axi_m_wready;
    logic [31:0]           axi_m_wdata;
    logic [3:0]            axi_m_wstrb;
    logic                  axi_m_bvalid;
    logic                  axi_m_bready;
    logic [1:0]            axi_m_bresp;
    logic                  axi_m_arvalid;
    logic                  axi_m_arready;
    logic [ADDR_WIDTH-1:0] axi_m_araddr;
    logic [2:0]            axi_m_arprot;
    logic                  axi_m_rvalid;
    logic                  axi_m_rready;
    logic [31:0]           axi_m_rdata;
    logic [1:0]            axi_m_rresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
        output axi_m_awvalid, axi_m_awaddr, axi_m_awprot,
        input  axi_m_awready,
        output axi_m_wvalid, axi_m_wdata, axi_m_wstrb,
        input  axi_m_wready,
        input  axi_m_bvalid, axi_m_bresp,
        output axi_m_bready,
        output axi_m_arvalid, axi_m_araddr, axi_m_arprot,
        input  axi_m_arready,
        input  axi_m_rvalid, axi_m_rdata, axi_m_rresp,
        output axi_m_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  axi_m_awvalid, axi_m_awaddr, axi_m_awprot,
        output axi_m_awready,
        input  axi_m_wvalid, axi_m_wdata, axi_m_wstrb,
        output axi_m_wready,
        output axi_m_bvalid, axi_m_bresp,
        input  axi_m_bready,
        input  axi_m_arvalid, axi_m_araddr, axi_m_arprot,
        output axi_m_arready,
        output axi_m_rvalid, axi_m_rdata, axi_m_rresp,
        input  axi_m_rready
    );
endinterface

// File: rtl/dft_axil_master.sv
// AXI4-Lite initiator issuing one register read or write per command, one transaction in flight.
// All bus and response outputs are registered; only cmd_ready is decoded from the state.
module dft_axil_master #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input logic                axi_m_aclk,
    input logic                axi_m_aresetn,
    dft_axil_master_if.master  bus
);
    typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR} state_e;

    state_e                state_q, state_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [31:0]           wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  cmd_fire, aw_done, w_done;

    assign bus.cmd_ready = (state_q == StIdle);
    assign cmd_fire      = bus.cmd_valid & (state_q == StIdle);
    // A channel is finished once its VALID has dropped or is being accepted this cycle.
    assign aw_done       = ~awvalid_q | bus.axi_m_awready;
    assign w_done        = ~wvalid_q | bus.axi_m_wready;

    always_ff @(posedge axi_m_aclk or negedge axi_m_aresetn) begin
        if (!axi_m_aresetn) begin
            state_q     <= StIdle;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_fire) state_d = bus.cmd_write ? StWrAwW : StRdAr;
            StWrAwW: if (aw_done && w_done) state_d = StWrB;
            StWrB:   if (bus.axi_m_bvalid && bready_q) state_d = StIdle;
            StRdAr:  if (arvalid_q && bus.axi_m_arready) state_d = StRdR;
            StRdR:   if (bus.axi_m_rvalid && rready_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    if (bus.cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = bus.cmd_addr;
                        wdata_d   = bus.cmd_wdata;
                        wstrb_d   = bus.cmd_wstrb;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = bus.cmd_addr;
                    end
                end
            end
            StWrAwW: begin
                awvalid_d = awvalid_q & ~bus.axi_m_awready;
                wvalid_d  = wvalid_q & ~bus.axi_m_wready;
                if (aw_done && w_done) bready_d = 1'b1;
            end
            StWrB: begin
                if (bus.axi_m_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = bus.axi_m_bresp;
                    rsp_rdata_d = '0;
                end
            end
            StRdAr: begin
                if (arvalid_q && bus.axi_m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdR: begin
                if (bus.axi_m_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus.axi_m_rdata;
                    rsp_resp_d  = bus.axi_m_rresp;
                end
            end
            default: ;
        endcase
    end

    assign bus.axi_m_awvalid = awvalid_q;
    assign bus.axi_m_awaddr  = awaddr_q;
    assign bus.axi_m_awprot  = AXI_PROT;
    assign bus.axi_m_wvalid  = wvalid_q;
    assign bus.axi_m_wdata   = wdata_q;
    assign bus.axi_m_wstrb   = wstrb_q;
    assign bus.axi_m_bready  = bready_q;
    assign bus.axi_m_arvalid = arvalid_q;
    assign bus.axi_m_araddr  = araddr_q;
    assign bus.axi_m_arprot  = AXI_PROT;
    assign bus.axi_m_rready  = rready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
endmodule
